// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the up/down sweep controller.
package counter_ctrl_pkg;

  localparam int DEF_SIZE    = 4;
  localparam int DEF_MAX_REP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequences an external up/down counter through `reps`
// triangular sweeps 0 -> target -> 0.
// Optional feature: define COUNTER_CTRL_PAUSE_EN to add the `hold` input,
// which freezes the sweep (enable forced low, state held) while busy.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int MAX_REP = DEF_MAX_REP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [SIZE-1:0]    target,
  input  logic [MAX_REP-1:0] reps,
  input  logic [SIZE-1:0]    count,
  input  logic               pulse,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic               hold,
`endif
  output logic               enable,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MAX_REP-1:0] sweeps_left
);

  state_t             state;
  logic [SIZE-1:0]    target_r;
  logic [MAX_REP-1:0] sweeps_r;
  logic               frozen;
  logic               run_state;

  assign run_state = (state == UP) || (state == DOWN);

`ifdef COUNTER_CTRL_PAUSE_EN
  assign frozen = hold && run_state;
`else
  assign frozen = 1'b0;
`endif

  // Moore output decode from the state register; hold masks the enable only
  always_comb begin
    enable  = 1'b0;
    up_down = 1'b1;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      UP: begin
        enable = ~frozen;
        busy   = 1'b1;
      end
      DOWN: begin
        enable  = ~frozen;
        up_down = 1'b0;
        busy    = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sweeps_left = sweeps_r;

  // Sequencing FSM: abort/wrap first, then hold, then the sweep transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      target_r <= '0;
      sweeps_r <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (run_state && (abort || pulse)) begin
        // a wrap from the counter means it left the planned range: fatal
        state    <= IDLE;
        sweeps_r <= '0;
        err      <= 1'b1;
      end else if (!frozen) begin
        case (state)
          IDLE: begin
            if (start) begin
              if (count == '0 && target != '0 && reps != '0) begin
                target_r <= target;
                sweeps_r <= reps;
                state    <= UP;
              end else begin
                err <= 1'b1;
              end
            end
          end
          UP: begin
            // counter lands on the peak at this same edge
            if (count == target_r - SIZE'(1)) state <= DOWN;
          end
          DOWN: begin
            if (count == SIZE'(1)) begin
              sweeps_r <= sweeps_r - MAX_REP'(1);
              state    <= (sweeps_r == MAX_REP'(1)) ? DONE : UP;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: a behavioural up/down counter sits beside the DUT,
// expected per-cycle output vectors are queued when stimulus is driven and
// compared at the falling edge of the cycle they belong to.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, abort, pulse;
  logic [3:0] target, reps, count, sweeps_left;
  logic       enable, up_down, busy, done, err;
  logic       ld, force_pulse;
  logic [3:0] ld_val;
`ifdef COUNTER_CTRL_PAUSE_EN
  logic       hold;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];

  counter_ctrl #(.SIZE(4), .MAX_REP(4)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .target(target),
    .reps(reps),
    .count(count),
    .pulse(pulse),
`ifdef COUNTER_CTRL_PAUSE_EN
    .hold(hold),
`endif
    .enable(enable),
    .up_down(up_down),
    .busy(busy),
    .done(done),
    .err(err),
    .sweeps_left(sweeps_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // controlled counter model, loadable from the bench
  always @(posedge clk) begin
    if (ld) count <= ld_val;
    else if (enable) count <= up_down ? count + 4'd1 : count - 4'd1;
  end

  assign pulse = force_pulse | (enable & (up_down ? (count == 4'hF) : (count == 4'h0)));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  // vector layout: {count, enable, up_down, busy, done, err, sweeps_left}
  task automatic push(input int c, input string tag, input int cnt, input int en,
                      input int ud, input int bz, input int dn, input int er, input int sw);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.v   = {4'(cnt), 1'(en), 1'(ud), 1'(bz), 1'(dn), 1'(er), 4'(sw)};
    q.push_back(e);
  endtask

  // Expected timeline of a sweep run whose start is high in cycle c0:
  // UP shows count 0..T-1, DOWN shows T..1, repeated R times, then DONE, IDLE.
  task automatic push_run(input int c0, input int t, input int r, input int nb,
                          input bit tail, input int hi, input int hl, input string tag);
    int c;
    int j;
    int p;
    int cv;
    int u;
    c = c0 + 1;
    for (int i = 0; i < 2 * t * r && i < nb; i++) begin
      j  = i / (2 * t);
      p  = i % (2 * t);
      u  = (p < t) ? 1 : 0;
      cv = (p < t) ? p : 2 * t - p;
      if (i == hi) begin
        for (int h = 0; h < hl; h++) begin
          push(c, tag, cv, 0, u, 1, 0, 0, r - j);
          c++;
        end
      end
      push(c, tag, cv, 1, u, 1, 0, 0, r - j);
      c++;
    end
    if (tail) begin
      push(c, tag, 0, 0, 1, 0, 1, 0, 0);
      push(c + 1, tag, 0, 0, 1, 0, 0, 0, 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_late"}, 16'(cyc), 16'(e.cyc));
      else chk(e.tag, {3'b0, count, enable, up_down, busy, done, err, sweeps_left}, {3'b0, e.v});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) tick();
    chk("drain", 16'(q.size()), 16'd0);
    q.delete();
  endtask

  task automatic load(input logic [3:0] v);
    ld     = 1'b1;
    ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  // starts a run and returns the cycle in which start was high
  task automatic go(input logic [3:0] t, input logic [3:0] r, output int c0);
    target = t;
    reps   = r;
    start  = 1'b1;
    c0     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic reject(input logic [3:0] cv, input logic [3:0] t, input logic [3:0] r,
                        input string tag);
    int c;
    load(cv);
    go(t, r, c);
    push(c + 1, tag, cv, 0, 1, 0, 0, 1, 0);
    push(c + 2, tag, cv, 0, 1, 0, 0, 0, 0);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; force_pulse = 1'b0;
    target = '0; reps = '0; ld = 1'b1; ld_val = '0;
`ifdef COUNTER_CTRL_PAUSE_EN
    hold = 1'b0;
`endif
    tick();
    tick();
    push(cyc, "reset", 0, 0, 1, 0, 0, 0, 0);
    reset = 1'b0;
    ld    = 1'b0;
    tick();

    // basic two-sweep run, with a start attempt mid-sweep that must be ignored
    go(4'd3, 4'd2, c0);
    push_run(c0, 3, 2, 100, 1'b1, -1, 0, "sweep_3x2");
    tick(); tick(); tick();
    target = 4'd1; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // abort in idle: no effect, no err
    abort = 1'b1;
    push(cyc + 1, "abort_idle", 0, 0, 1, 0, 0, 0, 0);
    tick();
    abort = 1'b0;
    drain();

    // rejected starts
    reject(4'd5, 4'd3, 4'd2, "rej_count");
    reject(4'd0, 4'd0, 4'd2, "rej_target");
    reject(4'd0, 4'd3, 4'd0, "rej_reps");

    // abort in the third UP cycle
    go(4'd7, 4'd1, c0);
    push_run(c0, 7, 1, 3, 1'b0, -1, 0, "abort_up");
    tick(); tick();
    abort = 1'b1;
    push(c0 + 4, "abort_up", 3, 0, 1, 0, 0, 1, 0);
    push(c0 + 5, "abort_up", 3, 0, 1, 0, 0, 0, 0);
    tick();
    abort = 1'b0;
    drain();
    load(4'd0);

    // forced wrap pulse during UP
    go(4'd15, 4'd1, c0);
    push_run(c0, 15, 1, 5, 1'b0, -1, 0, "pulse_up");
    tick(); tick(); tick(); tick();
    force_pulse = 1'b1;
    push(c0 + 6, "pulse_up", 5, 0, 1, 0, 0, 1, 0);
    push(c0 + 7, "pulse_up", 5, 0, 1, 0, 0, 0, 0);
    tick();
    force_pulse = 1'b0;
    drain();
    load(4'd0);

    // reset in the middle of DOWN, then restart once the counter is back at 0
    go(4'd3, 4'd1, c0);
    push_run(c0, 3, 1, 5, 1'b0, -1, 0, "rst_mid");
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    push(c0 + 6, "rst_mid", 1, 0, 1, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    drain();
    reject(4'd1, 4'd3, 4'd1, "rej_after_rst");
    load(4'd0);
    go(4'd2, 4'd1, c0);
    push_run(c0, 2, 1, 100, 1'b1, -1, 0, "restart");
    drain();

`ifdef COUNTER_CTRL_PAUSE_EN
    // hold for 4 cycles while the counter sits at 2
    go(4'd3, 4'd1, c0);
    push_run(c0, 3, 1, 100, 1'b1, 2, 4, "hold");
    tick(); tick();
    hold = 1'b1;
    tick(); tick(); tick(); tick();
    hold = 1'b0;
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 4: width of the controlled up/down counter.
REQ-002 SHALL have parameter MAX_REP, default 4: width of the repeat-count field.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a sweep sequence.
REQ-006 SHALL have port abort  input  1: stop the sequence and return to idle.
REQ-007 SHALL have port target  input  SIZE: sweep peak value, sampled on accepted start.
REQ-008 SHALL have port reps  input  MAX_REP: number of up/down sweeps, sampled on accepted start.
REQ-009 SHALL have port count  input  SIZE: current value from the controlled counter.
REQ-010 SHALL have port pulse  input  1: wrap pulse from the controlled counter.
REQ-011 SHALL have port enable  output  1: counter enable.
REQ-012 SHALL have port up_down  output  1: counter direction, 1 = up.
REQ-013 SHALL have port busy  output  1: a sequence is in progress.
REQ-014 SHALL have port done  output  1: one-cycle pulse on normal completion.
REQ-015 SHALL have port err  output  1: one-cycle pulse on a rejected start, a wrap, or an abort.
REQ-016 SHALL have port sweeps_left  output  MAX_REP: remaining sweeps, including the current one.

Function
REQ-017 SHALL implement the FSM states IDLE, UP, DOWN and DONE, with Moore outputs decoded from the state register.
REQ-018 SHALL drive enable=1, up_down=1 in UP; enable=1, up_down=0 in DOWN; enable=0, up_down=1 in IDLE and DONE.
REQ-019 SHALL, in IDLE, accept start only when count==0, target!=0 and reps!=0: latch target and reps, then go to UP on the next edge.
REQ-020 SHALL, on start in IDLE that violates REQ-019, stay in IDLE and pulse err for 1 cycle.
REQ-021 SHALL, in UP, go to DOWN on the edge where count==target-1, so the counter reaches target on that same edge; the peak is held for exactly 1 cycle.
REQ-022 SHALL, in DOWN on the edge where count==1, decrement sweeps_left, then go to DONE if the result is 0, else go to UP.
REQ-023 SHALL, in DONE, pulse done for 1 cycle and go to IDLE on the next edge.
REQ-024 SHALL assert busy in UP and DOWN only.
REQ-025 SHALL give start-to-first-enable latency of 1 cycle and a total busy time of exactly 2*target*reps cycles.
REQ-026 SHALL, on abort while busy, go to IDLE on the next edge, pulse err, and clear sweeps_left; abort has priority over all other transitions.
REQ-027 SHALL, on pulse while busy, treat it as a fatal error and respond as for abort.
REQ-028 SHALL ignore start while busy or in DONE.
REQ-029 SHALL ignore abort in IDLE, with no err.

Reset
REQ-030 SHALL, on reset, force IDLE, enable=0, up_down=1, busy=0, done=0, err=0, sweeps_left=0, and clear the latched target.
REQ-031 SHALL give reset priority over start, abort and pulse; reset mid-sweep takes effect at the next edge.

Configuration
REQ-032 SHALL, with COUNTER_CTRL_PAUSE_EN defined, add port hold (input, 1): while hold=1 and busy, drive enable=0 and freeze the state and sweep timing; abort still applies.
REQ-033 SHALL, without COUNTER_CTRL_PAUSE_EN, have no hold port and behave exactly per REQ-017 to REQ-031.

Structure
REQ-034 SHALL place the state enum type (IDLE/UP/DOWN/DONE) and default width constants in package counter_ctrl_pkg.
REQ-035 SHALL be a single flat module with no sub-modules; the verification bench instantiates it beside the existing counter.

Verification
REQ-036 SHALL cover: SIZE=4, target=3, reps=2, start at count=0 -> count sequence 1,2,3,2,1,0,1,2,3,2,1,0; done at cycle 13; busy for 12 cycles.
REQ-037 SHALL cover: start with count=5, or with target=0, or with reps=0 -> err for 1 cycle, enable stays 0, busy stays 0.
REQ-038 SHALL cover: abort in the 3rd UP cycle with target=7 -> next cycle IDLE, err=1, sweeps_left=0, count frozen at 3.
REQ-039 SHALL cover: target=15, reps=1, and a forced pulse during UP -> err, IDLE, enable=0.
REQ-040 SHALL cover: reset asserted mid-DOWN -> all outputs at reset values on the next edge; a later start succeeds once count==0.
REQ-041 SHALL cover, with COUNTER_CTRL_PAUSE_EN: hold=1 for 4 cycles at count=2 -> count stays 2 and busy time grows by exactly 4 cycles.
